pc_gen: RTL and testbench

Parametrised program-counter generator for the fetch stage; successor to the fixed 32-bit, branch-only PC register. It produces the next instruction address from a configurable reset vector and increment. A trap redirect has priority over a branch redirect. A redirect that arrives while fetch is stalled is held in a one-entry pending buffer, so it is never lost. The block sits between the ctrl/id/trap logic and the instruction-memory address port.

---
 rtl/pc_gen.sv | 151 +++++++++++++++
 tb/tb_pc_gen.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_gen.sv
// pc_gen -- program-counter generator for the fetch stage.
//
// Produces the next instruction fetch address from a configurable reset
// vector and sequential increment. Trap redirects take priority over branch
// redirects. A redirect that arrives while fetch is stalled is parked in a
// one-entry pending buffer and applied on the first unstalled edge, unless a
// fresh redirect on that same edge overrides it.
//
// Ports:
//   clk                     : clock, all state updates on posedge
//   rst                     : synchronous reset, active-low
//   stall                   : stall vector from ctrl; only stall[0] is used
//   branch_flag_i           : branch redirect request from id
//   branch_target_address_i : branch target
//   trap_flag_i             : trap/exception redirect request
//   trap_target_i           : trap vector
//   pc                      : current fetch address (registered)
//   ce                      : fetch enable (registered)
//   redirect_pending_o      : pending buffer holds an unapplied redirect
//   redirect_taken_o        : one-cycle pulse, pc loaded from a redirect source
module pc_gen #(
  parameter int unsigned              ADDR_W     = 32,
  parameter logic [ADDR_W-1:0]        RESET_PC   = '0,
  parameter int unsigned              INC        = 4,
  parameter int unsigned              ALIGN_BITS = 1,
  parameter int unsigned              STALL_W    = 6
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [STALL_W-1:0]  stall,
  input  logic                branch_flag_i,
  input  logic [ADDR_W-1:0]   branch_target_address_i,
  input  logic                trap_flag_i,
  input  logic [ADDR_W-1:0]   trap_target_i,
  output logic [ADDR_W-1:0]   pc,
  output logic                ce,
  output logic                redirect_pending_o,
  output logic                redirect_taken_o
);

  typedef enum logic {S_RST, S_RUN} state_t;

  // Clears the low ALIGN_BITS of any redirect target; all ones when ALIGN_BITS=0.
  localparam logic [ADDR_W-1:0] ALIGN_MASK =
    ~((ADDR_W'(1) << ALIGN_BITS) - ADDR_W'(1));
  localparam logic [ADDR_W-1:0] INC_W = ADDR_W'(INC);

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic                ce_q, ce_d;
  logic                taken_q, taken_d;
  logic                pend_valid_q, pend_valid_d;
  logic                pend_is_trap_q, pend_is_trap_d;
  logic [ADDR_W-1:0]   pend_target_q, pend_target_d;

  logic [ADDR_W-1:0]   trap_al, branch_al;
  logic                stall_hold;

  assign trap_al    = trap_target_i & ALIGN_MASK;
  assign branch_al  = branch_target_address_i & ALIGN_MASK;
  assign stall_hold = stall[0];

  // Upper stall bits belong to other pipeline stages.
  generate
    if (STALL_W > 1) begin : g_stall_unused
      logic stall_hi_unused;
      assign stall_hi_unused = ^stall[STALL_W-1:1];
    end
  endgenerate

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    state_d        = state_q;
    pc_d           = pc_q;
    ce_d           = ce_q;
    taken_d        = 1'b0;
    pend_valid_d   = pend_valid_q;
    pend_is_trap_d = pend_is_trap_q;
    pend_target_d  = pend_target_q;

    unique case (state_q)
      S_RST: begin
        // Leaving reset: enable fetch at the reset vector, ignore flags/stall.
        state_d      = S_RUN;
        ce_d         = 1'b1;
        pc_d         = RESET_PC;
        pend_valid_d = 1'b0;
      end
      S_RUN: begin
        if (!stall_hold) begin
          if (trap_flag_i) begin
            pc_d    = trap_al;
            taken_d = 1'b1;
          end else if (branch_flag_i) begin
            pc_d    = branch_al;
            taken_d = 1'b1;
          end else if (pend_valid_q) begin
            pc_d    = pend_target_q;
            taken_d = 1'b1;
          end else begin
            pc_d    = pc_q + INC_W;
          end
          pend_valid_d = 1'b0;
        end else begin
          // Stalled: pc holds; a trap overwrites anything, a branch never
          // displaces a held trap.
          if (trap_flag_i) begin
            pend_valid_d   = 1'b1;
            pend_is_trap_d = 1'b1;
            pend_target_d  = trap_al;
          end else if (branch_flag_i && !(pend_valid_q && pend_is_trap_q)) begin
            pend_valid_d   = 1'b1;
            pend_is_trap_d = 1'b0;
            pend_target_d  = branch_al;
          end
        end
      end
      default: state_d = S_RST;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk) begin
    // NOTE: the pending target is data qualified by pend_valid_q, so it needs
    // no reset; only the control flops are cleared.
    pend_target_q <= pend_target_d;
    if (!rst) begin
      state_q        <= S_RST;
      pc_q           <= RESET_PC;
      ce_q           <= 1'b0;
      taken_q        <= 1'b0;
      pend_valid_q   <= 1'b0;
      pend_is_trap_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      pc_q           <= pc_d;
      ce_q           <= ce_d;
      taken_q        <= taken_d;
      pend_valid_q   <= pend_valid_d;
      pend_is_trap_q <= pend_is_trap_d;
    end
  end

  assign pc                 = pc_q;
  assign ce                 = ce_q;
  assign redirect_pending_o = pend_valid_q;
  assign redirect_taken_o   = taken_q;

endmodule

// File: tb/tb_pc_gen.sv
// Directed testbench for pc_gen: default-parameter instance for the main
// features plus a 16-bit instance for address wrap-around.
module tb_pc_gen;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  stall;
  logic        branch_flag_i;
  logic [31:0] branch_target_address_i;
  logic        trap_flag_i;
  logic [31:0] trap_target_i;
  logic [31:0] pc;
  logic        ce;
  logic        redirect_pending_o;
  logic        redirect_taken_o;

  logic [15:0] pc2;
  logic        ce2, pend2, taken2;

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  pc_gen dut (
    .clk                     (clk),
    .rst                     (rst),
    .stall                   (stall),
    .branch_flag_i           (branch_flag_i),
    .branch_target_address_i (branch_target_address_i),
    .trap_flag_i             (trap_flag_i),
    .trap_target_i           (trap_target_i),
    .pc                      (pc),
    .ce                      (ce),
    .redirect_pending_o      (redirect_pending_o),
    .redirect_taken_o        (redirect_taken_o)
  );

  pc_gen #(.ADDR_W(16), .RESET_PC(16'hFFF8), .INC(4)) dut16 (
    .clk                     (clk),
    .rst                     (rst),
    .stall                   (stall),
    .branch_flag_i           (1'b0),
    .branch_target_address_i (16'h0000),
    .trap_flag_i             (1'b0),
    .trap_target_i           (16'h0000),
    .pc                      (pc2),
    .ce                      (ce2),
    .redirect_pending_o      (pend2),
    .redirect_taken_o        (taken2)
  );

  // Advance one edge; outputs are sampled 1 time unit after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    step();
    step();
    tests_run++;
    if (pc !== 32'h0) begin tests_failed++; $display("FAIL reset_pc: got %h exp %h", pc, 32'h0); end
    tests_run++;
    if (ce !== 1'b0) begin tests_failed++; $display("FAIL reset_ce: got %b exp 0", ce); end
    tests_run++;
    if (redirect_pending_o !== 1'b0) begin tests_failed++; $display("FAIL reset_pend: got %b exp 0", redirect_pending_o); end
    tests_run++;
    if (redirect_taken_o !== 1'b0) begin tests_failed++; $display("FAIL reset_taken: got %b exp 0", redirect_taken_o); end
  endtask

  task automatic test_free_run();
    logic [31:0] exp_pc [4] = '{32'h0, 32'h4, 32'h8, 32'hC};
    rst = 1'b1;
    step();
    tests_run++;
    if (ce !== 1'b1) begin tests_failed++; $display("FAIL run_ce: got %b exp 1", ce); end
    for (int i = 0; i < 4; i++) begin
      if (i > 0) step();
      tests_run++;
      if (pc !== exp_pc[i]) begin tests_failed++; $display("FAIL run_pc[%0d]: got %h exp %h", i, pc, exp_pc[i]); end
    end
    tests_run++;
    if (redirect_taken_o !== 1'b0) begin tests_failed++; $display("FAIL run_taken: got %b exp 0", redirect_taken_o); end
  endtask

  task automatic test_branch();
    branch_flag_i = 1'b1;
    branch_target_address_i = 32'h0000_0103;
    step();
    branch_flag_i = 1'b0;
    tests_run++;
    if (pc !== 32'h102) begin tests_failed++; $display("FAIL branch_pc: got %h exp %h", pc, 32'h102); end
    tests_run++;
    if (redirect_taken_o !== 1'b1) begin tests_failed++; $display("FAIL branch_taken: got %b exp 1", redirect_taken_o); end
    step();
    tests_run++;
    if (pc !== 32'h106) begin tests_failed++; $display("FAIL branch_next_pc: got %h exp %h", pc, 32'h106); end
    tests_run++;
    if (redirect_taken_o !== 1'b0) begin tests_failed++; $display("FAIL branch_taken_drop: got %b exp 0", redirect_taken_o); end
  endtask

  task automatic test_stall_branch();
    stall = 6'b000001;
    branch_flag_i = 1'b1;
    branch_target_address_i = 32'h200;
    step();
    branch_flag_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) step();
      tests_run++;
      if (pc !== 32'h106) begin tests_failed++; $display("FAIL stall_pc[%0d]: got %h exp %h", i, pc, 32'h106); end
      tests_run++;
      if (redirect_pending_o !== 1'b1) begin tests_failed++; $display("FAIL stall_pend[%0d]: got %b exp 1", i, redirect_pending_o); end
      tests_run++;
      if (redirect_taken_o !== 1'b0) begin tests_failed++; $display("FAIL stall_taken[%0d]: got %b exp 0", i, redirect_taken_o); end
    end
    stall = 6'b0;
    step();
    tests_run++;
    if (pc !== 32'h200) begin tests_failed++; $display("FAIL release_pc: got %h exp %h", pc, 32'h200); end
    tests_run++;
    if (redirect_pending_o !== 1'b0) begin tests_failed++; $display("FAIL release_pend: got %b exp 0", redirect_pending_o); end
    tests_run++;
    if (redirect_taken_o !== 1'b1) begin tests_failed++; $display("FAIL release_taken: got %b exp 1", redirect_taken_o); end
    step();
    tests_run++;
    if (pc !== 32'h204) begin tests_failed++; $display("FAIL release_next_pc: got %h exp %h", pc, 32'h204); end
    tests_run++;
    if (redirect_taken_o !== 1'b0) begin tests_failed++; $display("FAIL release_taken_once: got %b exp 0", redirect_taken_o); end
  endtask

  task automatic test_priority();
    // Stalled: trap first, later branch must not displace it.
    stall = 6'b000001;
    trap_flag_i = 1'b1;
    trap_target_i = 32'h80;
    step();
    trap_flag_i = 1'b0;
    branch_flag_i = 1'b1;
    branch_target_address_i = 32'h300;
    step();
    branch_flag_i = 1'b0;
    stall = 6'b0;
    step();
    tests_run++;
    if (pc !== 32'h80) begin tests_failed++; $display("FAIL prio_held_trap_pc: got %h exp %h", pc, 32'h80); end

    // Unstalled: simultaneous trap and branch, trap wins (and is aligned).
    trap_flag_i = 1'b1;
    trap_target_i = 32'h41;
    branch_flag_i = 1'b1;
    branch_target_address_i = 32'h300;
    step();
    trap_flag_i = 1'b0;
    branch_flag_i = 1'b0;
    tests_run++;
    if (pc !== 32'h40) begin tests_failed++; $display("FAIL prio_same_cycle_pc: got %h exp %h", pc, 32'h40); end

    // Stalled: trap overwrites a held branch.
    stall = 6'b000001;
    branch_flag_i = 1'b1;
    branch_target_address_i = 32'h700;
    step();
    branch_flag_i = 1'b0;
    trap_flag_i = 1'b1;
    trap_target_i = 32'h90;
    step();
    trap_flag_i = 1'b0;
    stall = 6'b0;
    step();
    tests_run++;
    if (pc !== 32'h90) begin tests_failed++; $display("FAIL prio_trap_over_branch_pc: got %h exp %h", pc, 32'h90); end

    // A flag on the release edge overrides the pending redirect.
    stall = 6'b000001;
    branch_flag_i = 1'b1;
    branch_target_address_i = 32'h500;
    step();
    stall = 6'b0;
    branch_target_address_i = 32'h600;
    step();
    branch_flag_i = 1'b0;
    tests_run++;
    if (pc !== 32'h600) begin tests_failed++; $display("FAIL override_pc: got %h exp %h", pc, 32'h600); end
    tests_run++;
    if (redirect_pending_o !== 1'b0) begin tests_failed++; $display("FAIL override_pend: got %b exp 0", redirect_pending_o); end
    step();
    tests_run++;
    if (pc !== 32'h604) begin tests_failed++; $display("FAIL override_next_pc: got %h exp %h", pc, 32'h604); end
  endtask

  task automatic test_wrap();
    logic [15:0] exp_pc [4] = '{16'hFFF8, 16'hFFFC, 16'h0000, 16'h0004};
    rst = 1'b0;
    step();
    tests_run++;
    if (pc2 !== 16'hFFF8 || ce2 !== 1'b0) begin tests_failed++; $display("FAIL wrap_reset: got pc=%h ce=%b exp pc=fff8 ce=0", pc2, ce2); end
    rst = 1'b1;
    step();
    for (int i = 0; i < 4; i++) begin
      if (i > 0) step();
      tests_run++;
      if (pc2 !== exp_pc[i]) begin tests_failed++; $display("FAIL wrap_pc[%0d]: got %h exp %h", i, pc2, exp_pc[i]); end
    end
  endtask

  task automatic test_reset_mid();
    stall = 6'b000001;
    branch_flag_i = 1'b1;
    branch_target_address_i = 32'h800;
    step();
    branch_flag_i = 1'b0;
    tests_run++;
    if (redirect_pending_o !== 1'b1) begin tests_failed++; $display("FAIL mid_pend_set: got %b exp 1", redirect_pending_o); end
    rst = 1'b0;
    step();
    tests_run++;
    if (pc !== 32'h0) begin tests_failed++; $display("FAIL mid_reset_pc: got %h exp %h", pc, 32'h0); end
    tests_run++;
    if (ce !== 1'b0) begin tests_failed++; $display("FAIL mid_reset_ce: got %b exp 0", ce); end
    tests_run++;
    if (redirect_pending_o !== 1'b0) begin tests_failed++; $display("FAIL mid_reset_pend: got %b exp 0", redirect_pending_o); end
    rst = 1'b1;
    stall = 6'b0;
    step();
    tests_run++;
    if (pc !== 32'h0 || ce !== 1'b1) begin tests_failed++; $display("FAIL mid_exit: got pc=%h ce=%b exp pc=0 ce=1", pc, ce); end
    step();
    tests_run++;
    if (pc !== 32'h4) begin tests_failed++; $display("FAIL mid_no_stale_redirect: got %h exp %h", pc, 32'h4); end
    tests_run++;
    if (redirect_taken_o !== 1'b0) begin tests_failed++; $display("FAIL mid_taken: got %b exp 0", redirect_taken_o); end
  endtask

  initial begin
    rst = 1'b0;
    stall = 6'b0;
    branch_flag_i = 1'b0;
    branch_target_address_i = 32'h0;
    trap_flag_i = 1'b0;
    trap_target_i = 32'h0;

    test_reset();
    test_free_run();
    test_branch();
    test_stall_branch();
    test_priority();
    test_wrap();
    test_reset_mid();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
